// File: rtl/count_timer_ctrl_pkg.sv
// Shared types and default widths for the interval timer control stage.
package timer_pkg;

  localparam int unsigned TIMER_N     = 12;
  localparam int unsigned TIMER_RLD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE
  } state_t;

endpackage

// File: rtl/count_timer_ctrl_if.sv
// Timer control bundle: host controls, comparator operands and borrow, status outputs.
interface count_timer_ctrl_if #(
  parameter int unsigned N     = timer_pkg::TIMER_N,
  parameter int unsigned RLD_W = timer_pkg::TIMER_RLD_W
);

  logic             start;
  logic             stop;
  logic             pause;
  logic             auto_reload;
  logic [N-1:0]     limit_in;
  logic             cmp_borrow;
  logic [N-1:0]     counter;
  logic [N-1:0]     cons;
  logic             busy;
  logic             done;
  logic [RLD_W-1:0] reload_cnt;

  // master is the parent side that owns the controls and the comparator output
  modport master (
    output start, stop, pause, auto_reload, limit_in, cmp_borrow,
    input  counter, cons, busy, done, reload_cnt
  );

  modport slave (
    input  start, stop, pause, auto_reload, limit_in, cmp_borrow,
    output counter, cons, busy, done, reload_cnt
  );

endinterface

// File: rtl/count_timer_ctrl.sv
// One-shot / auto-reload interval timer driving an external borrow comparator;
// expiry is taken from the comparator's borrow-out.
module count_timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned N     = TIMER_N,
  parameter int unsigned RLD_W = TIMER_RLD_W
) (
  input  logic              clk,
  input  logic              rst,
  count_timer_ctrl_if.slave bus
);

  state_t           state, state_next;
  logic [N-1:0]     counter_q, counter_next;
  logic [N-1:0]     cons_q, cons_next;
  logic [RLD_W-1:0] rld_q, rld_next;
  logic             done_q, done_next;
  logic             busy_q;
  logic             expire;

  // An all-ones counter is treated as expiry even if the borrow disagrees.
  assign expire = !bus.cmp_borrow || (counter_q == '1);

  // NOTE: state is only ever updated with <= so every register samples the
  // same pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      counter_q <= '0;
      cons_q    <= '0;
      rld_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_next;
      counter_q <= counter_next;
      cons_q    <= cons_next;
      rld_q     <= rld_next;
      done_q    <= done_next;
      busy_q    <= (state_next != ST_IDLE);
    end
  end

  // NOTE: every combinational output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:  if (bus.start) state_next = ST_RUN;
      ST_RUN: begin
        if (bus.stop)                 state_next = ST_IDLE;
        else if (expire)              state_next = bus.auto_reload ? ST_RUN : ST_IDLE;
        else if (bus.pause)           state_next = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (bus.stop)                 state_next = ST_IDLE;
        else if (!bus.pause)          state_next = ST_RUN;
      end
      default:                        state_next = ST_IDLE;
    endcase
  end

  // Datapath next values; pause and the paused-to-run transition both hold the count.
  always_comb begin
    counter_next = counter_q;
    cons_next    = cons_q;
    rld_next     = rld_q;
    done_next    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          cons_next    = bus.limit_in;
          counter_next = '0;
          rld_next     = '0;
        end
      end
      ST_RUN: begin
        if (bus.stop) begin
          counter_next = '0;
        end else if (expire) begin
          done_next = 1'b1;
          if (bus.auto_reload) begin
            counter_next = '0;
            rld_next     = (rld_q == '1) ? rld_q : rld_q + 1'b1;
          end
        end else if (!bus.pause) begin
          counter_next = counter_q + 1'b1;
        end
      end
      ST_PAUSE: begin
        if (bus.stop) counter_next = '0;
      end
      default: begin
        counter_next = '0;
      end
    endcase
  end

  assign bus.counter    = counter_q;
  assign bus.cons       = cons_q;
  assign bus.reload_cnt = rld_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;

endmodule

// File: doc/count_timer_ctrl.md
Name: count_timer_ctrl

Overview:
Control stage directly upstream of the 12-bit ripple-borrow comparator. It drives the comparator's `counter` and `cons` operands and consumes its borrow-out (`Cout`) to decide expiry. It runs a programmable one-shot or auto-reload interval timer for the processor's peripheral/timing logic, and emits a one-cycle `done` pulse per interval.

Parameters:
N, 12, operand width; must match the comparator's N.
RLD_W, 8, width of the saturating reload counter.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  begin a timing interval; sampled only in IDLE.
stop  input  1  abort; sampled in RUN and PAUSE.
pause  input  1  level; freezes counting while high.
auto_reload  input  1  level; sampled at each expiry.
limit_in  input  N  interval limit; latched on accepted start.
cmp_borrow  input  1  comparator Cout; 1 when counter < cons.
counter  output  N  registered count, to comparator `counter`.
cons  output  N  registered latched limit, to comparator `cons`.
busy  output  1  high in RUN or PAUSE.
done  output  1  one-cycle registered expiry pulse.
reload_cnt  output  RLD_W  number of auto-reloads; saturates.

Behaviour:
- Reset is asynchronous, active-high. Its effects:
  - state=IDLE; counter=0; cons=0; done=0; busy=0; reload_cnt=0.
- All outputs are registered. cmp_borrow depends only on registered counter/cons, so there is no combinational loop.
- States: IDLE, RUN, PAUSE.
- IDLE:
  - start=1 latches cons<=limit_in, counter<=0, reload_cnt<=0, and moves to RUN on the next edge.
  - Otherwise IDLE holds, and counter/cons keep their values.
- RUN, priority order:
  1. stop=1 -> IDLE; counter<=0; no done pulse.
  2. cmp_borrow=0 (counter>=cons) is expiry. Next edge: done<=1 for exactly one cycle.
     - If auto_reload=1: counter<=0, stay in RUN, reload_cnt<=reload_cnt+1 (saturates at all-ones).
     - Else: go to IDLE; counter holds its final value.
  3. pause=1 -> PAUSE; counter holds.
  4. Otherwise counter<=counter+1.
- PAUSE:
  - stop=1 -> IDLE, counter<=0.
  - pause=0 -> RUN; counter holds this cycle.
  - cmp_borrow is ignored in PAUSE.
- Expiry is checked before pause, so pause and expiry in the same cycle gives expiry.
- Latency: start sampled at edge E gives the first RUN cycle with counter=0 at E+1. For limit L, expiry is detected in the cycle where counter=L, and done is high in the cycle after edge E+L+2. With auto_reload, the period between done pulses is L+1 cycles.
- limit_in=0 expires in the first RUN cycle, so done follows 2 edges after start.
- Wrap-around: counter cannot exceed cons, which is at most 2^N-1, so counter never wraps.
  - Defensive rule: if counter is all-ones while cmp_borrow=1, treat it as expiry.
- start while busy is ignored; cons is not re-latched. start and stop together in IDLE: start is accepted.
- limit_in changes after start have no effect until the next accepted start.
- done is 0 in every cycle except the single pulse cycle.
- Reset asserted mid-interval returns immediately to reset values; no done pulse.

Decomposition:
- Shared package timer_pkg holds:
  - a typedef enum for the state (IDLE, RUN, PAUSE);
  - the localparam default width (12);
  - the reload width.
- No sub-module inside the block. The comparator is instantiated alongside it by the parent, not inside it.
- The bench instantiates count_timer_ctrl plus the comparator with the same N and loops Cout back to cmp_borrow.

Test Plan:
- Reset mid-RUN with limit=100, counter=40 -> all outputs return to 0 immediately, state IDLE, no done pulse.
- One-shot, limit_in=5, start pulse at edge E -> counter 0..5 on E+1..E+6; done high exactly one cycle after E+7; busy falls; counter holds 5.
- Auto-reload, limit_in=3, run 3 intervals -> done every 4 cycles, reload_cnt=1,2,3, counter sequence 0,1,2,3,0,...
- Pause on counter=2 for 4 cycles, limit=6 -> counter stays 2 while paused; done delayed by 5 cycles versus the unpaused run.
- Stop at counter=4 and start asserted during RUN with limit=10 -> mid-run start ignored; stop clears counter to 0, goes to IDLE, no done pulse.
- limit_in=0 and limit_in=12'hFFF; RLD_W=2 with 5 reloads -> done 2 edges after start; full-scale count with no wrap; reload_cnt saturates at 3.
